// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine between the pipeline and the data bus.
// Latency: accept at N, data_req at N+1, done_o at N+2 when both handshakes land at N+1.
// Backpressure: stall_o holds the pipeline until DONE. Bus stalls are absorbed in REQ and WAIT.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   valid_i/op_i/addr_i  MEM-stage instruction: op code, virtual effective address
//   rt_i                 store data and old rt value for the LWL/LWR merge
//   flush_i              pipeline flush; abandons or drains an in-flight access
//   stall_o, done_o      pipeline hold; one-cycle completion pulse
//   rdata_o              formatted load result, valid while done_o=1
//   adel_o/ades_o        combinational load/store address error; badvaddr_o mirrors addr_i
//   data_*               registered request bus (req/wr/size/wstrb/addr/wdata) and its handshakes
// Build option: define MEM_UNALIGNED_LWLR_EN to implement LWL/LWR/SWL/SWR (ops 9-C).
// Without it, those ops decode as no-ops.
module mem_access_unit #(
    parameter int MAP_KSEG = 1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       rt_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] badvaddr_o,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

    localparam logic [3:0] OP_LB  = 4'h1;
    localparam logic [3:0] OP_LBU = 4'h2;
    localparam logic [3:0] OP_LH  = 4'h3;
    localparam logic [3:0] OP_LHU = 4'h4;
    localparam logic [3:0] OP_LW  = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h6;
    localparam logic [3:0] OP_SH  = 4'h7;
    localparam logic [3:0] OP_SW  = 4'h8;
`ifdef MEM_UNALIGNED_LWLR_EN
    localparam logic [3:0] OP_LWL = 4'h9;
    localparam logic [3:0] OP_LWR = 4'hA;
    localparam logic [3:0] OP_SWL = 4'hB;
    localparam logic [3:0] OP_SWR = 4'hC;
`endif

    state_t            state_q, state_d;
    logic              req_q, req_d, wr_q, wr_d, done_q, done_d;
    logic [1:0]        size_q, size_d, off_q, off_d;
    logic [3:0]        wstrb_q, wstrb_d, op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef MEM_UNALIGNED_LWLR_EN
    logic [31:0]       rt_q, rt_d;
`endif

    // Instruction decode
    logic              is_load, is_store, is_unal, mis_align, mem_op, issue, capture;
    logic [1:0]        size_dec, off;
    logic [3:0]        wstrb_dec;
    logic [31:0]       wdata_dec, load_fmt;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [ADDR_W-1:0] vaddr, paddr;

    assign off = addr_i[1:0];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_unal   = 1'b0;
        mis_align = 1'b0;
        size_dec  = 2'd0;
        wstrb_dec = 4'b0000;
        wdata_dec = rt_i;
        case (op_i)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; size_dec = 2'd1; mis_align = addr_i[0]; end
            OP_LW:  begin is_load = 1'b1; size_dec = 2'd2; mis_align = |addr_i[1:0]; end
            OP_SB:  begin
                is_store = 1'b1; wstrb_dec = 4'b0001 << off; wdata_dec = {4{rt_i[7:0]}};
            end
            OP_SH:  begin
                is_store = 1'b1; size_dec = 2'd1; mis_align = addr_i[0];
                wstrb_dec = off[1] ? 4'b1100 : 4'b0011; wdata_dec = {2{rt_i[15:0]}};
            end
            OP_SW:  begin
                is_store = 1'b1; size_dec = 2'd2; mis_align = |addr_i[1:0]; wstrb_dec = 4'b1111;
            end
`ifdef MEM_UNALIGNED_LWLR_EN
            OP_LWL, OP_LWR: begin is_load = 1'b1; is_unal = 1'b1; size_dec = 2'd2; end
            OP_SWL: begin
                is_store = 1'b1; is_unal = 1'b1; size_dec = 2'd2;
                wstrb_dec = 4'b1111 >> (2'd3 - off);
                wdata_dec = rt_i >> {(2'd3 - off), 3'b000};
            end
            OP_SWR: begin
                is_store = 1'b1; is_unal = 1'b1; size_dec = 2'd2;
                wstrb_dec = 4'b1111 << off;
                wdata_dec = rt_i << {off, 3'b000};
            end
`endif
            default: ;
        endcase
    end

    assign mem_op     = is_load | is_store;
    assign adel_o     = valid_i & is_load & mis_align;
    assign ades_o     = valid_i & is_store & mis_align;
    assign badvaddr_o = addr_i;

    // Unaligned ops always access the containing word. kseg0/kseg1 fold to physical.
    always_comb begin
        vaddr = is_unal ? {addr_i[ADDR_W-1:2], 2'b00} : addr_i;
        paddr = vaddr;
        if (MAP_KSEG != 0 && vaddr[ADDR_W-1 -: 2] == 2'b10)
            paddr = {3'b000, vaddr[ADDR_W-4:0]};
    end

    // Load formatting from the returning word, using the op/offset latched at issue
    assign ld_byte = data_rdata[{off_q, 3'b000} +: 8];
    assign ld_half = data_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_fmt = data_rdata;
        case (op_q)
            OP_LB:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU: load_fmt = {24'h0, ld_byte};
            OP_LH:  load_fmt = {{16{ld_half[15]}}, ld_half};
            OP_LHU: load_fmt = {16'h0, ld_half};
`ifdef MEM_UNALIGNED_LWLR_EN
            // LWL fills the top k+1 bytes of rt. LWR fills the bottom 4-k bytes.
            OP_LWL: load_fmt = (data_rdata << {(2'd3 - off_q), 3'b000})
                             | (rt_q & ~(32'hFFFF_FFFF << {(2'd3 - off_q), 3'b000}));
            OP_LWR: load_fmt = (data_rdata >> {off_q, 3'b000})
                             | (rt_q & ~(32'hFFFF_FFFF >> {off_q, 3'b000}));
`endif
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid_i && mem_op && !mis_align && !flush_i) state_d = S_REQ;
            S_REQ: begin
                if (data_addr_ok) begin
                    // A flush after acceptance must still consume the data beat.
                    if (flush_i) state_d = data_data_ok ? S_IDLE : S_DRAIN;
                    else         state_d = data_data_ok ? S_DONE : S_WAIT;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush_i)           state_d = data_data_ok ? S_IDLE : S_DRAIN;
                else if (data_data_ok) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_DRAIN: if (data_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (rst) state_d = S_IDLE;
    end

    assign issue   = (state_q == S_IDLE) && (state_d == S_REQ);
    assign capture = (state_d == S_DONE);

    // Request fields are latched at issue and held until the next issue
    always_comb begin
        req_d   = (state_d == S_REQ);
        done_d  = (state_d == S_DONE);
        wr_d    = wr_q;
        size_d  = size_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        off_d   = off_q;
        if (issue) begin
            wr_d    = is_store;
            size_d  = size_dec;
            wstrb_d = is_store ? wstrb_dec : 4'b0000;
            addr_d  = paddr;
            wdata_d = wdata_dec;
            op_d    = op_i;
            off_d   = addr_i[1:0];
        end
        rdata_d = capture ? load_fmt : rdata_q;
    end

`ifdef MEM_UNALIGNED_LWLR_EN
    assign rt_d = issue ? rt_i : rt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            size_q  <= 2'd0;
            off_q   <= 2'd0;
            wstrb_q <= 4'b0000;
            op_q    <= 4'h0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef MEM_UNALIGNED_LWLR_EN
            rt_q    <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            size_q  <= size_d;
            off_q   <= off_d;
            wstrb_q <= wstrb_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_UNALIGNED_LWLR_EN
            rt_q    <= rt_d;
`endif
        end
    end

    // The accept cycle must stall combinationally. DONE releases the pipeline.
    assign stall_o = !rst && ((state_q == S_DRAIN) ||
                     (valid_i && mem_op && !mis_align && state_q != S_DONE));

    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_wstrb = wstrb_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign done_o     = done_q;
    assign rdata_o    = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized load/store traffic against a byte-level reference model.
// The driver plays both the pipeline and the memory, and it publishes per-cycle expectations.
// One negedge process compares every DUT output against those expectations.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst, valid_i, flush_i, data_addr_ok, data_data_ok;
    logic [3:0]  op_i;
    logic [31:0] addr_i, rt_i, data_rdata;
    logic        stall_o, done_o, adel_o, ades_o, data_req, data_wr;
    logic [31:0] rdata_o, badvaddr_o, data_addr, data_wdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;

    always #5 clk = ~clk;

    mem_access_unit #(.MAP_KSEG(1), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i), .rt_i(rt_i),
        .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o), .data_req(data_req),
        .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    int checks = 0;
    int failures = 0;

    // Per-cycle expectations published by the driver
    logic        chk_en, exp_zero, exp_stall, exp_req, exp_done, exp_fld, exp_ld, exp_st, exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference model
    function automatic bit m_is_load(input logic [3:0] op);
        bit r;
        r = (op >= 4'd1 && op <= 4'd5);
`ifdef MEM_UNALIGNED_LWLR_EN
        r = r || op == 4'd9 || op == 4'd10;
`endif
        return r;
    endfunction

    function automatic bit m_is_store(input logic [3:0] op);
        bit r;
        r = (op >= 4'd6 && op <= 4'd8);
`ifdef MEM_UNALIGNED_LWLR_EN
        r = r || op == 4'd11 || op == 4'd12;
`endif
        return r;
    endfunction

    function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] addr);
        if (op == 4'd3 || op == 4'd4 || op == 4'd7) return addr[0];
        if (op == 4'd5 || op == 4'd8) return addr[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_size(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 2'd0;
        if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] m_phys(input logic [3:0] op, input logic [31:0] addr);
        logic [31:0] a;
        a = (op >= 4'd9 && op <= 4'd12) ? (addr & 32'hFFFF_FFFC) : addr;
        if (a[31:30] == 2'b10) a = a & 32'h1FFF_FFFF;
        return a;
    endfunction

    function automatic void m_store(input logic [3:0] op, input logic [31:0] addr,
                                    input logic [31:0] rt, output logic [3:0] s,
                                    output logic [31:0] d);
        logic [7:0] rb[4];
        int k;
        k = int'(addr[1:0]);
        s = 4'b0000;
        d = 32'h0;
        for (int i = 0; i < 4; i++) rb[i] = rt[8*i +: 8];
        for (int i = 0; i < 4; i++) begin
            case (op)
                4'd6:  begin d[8*i +: 8] = rb[0];     s[i] = (i == k); end
                4'd7:  begin d[8*i +: 8] = rb[i % 2]; s[i] = (i / 2 == k / 2); end
                4'd8:  begin d[8*i +: 8] = rb[i];     s[i] = 1'b1; end
                4'd11: if (i <= k) begin d[8*i +: 8] = rb[i + 3 - k]; s[i] = 1'b1; end
                4'd12: if (i >= k) begin d[8*i +: 8] = rb[i - k];     s[i] = 1'b1; end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rt, input logic [31:0] mem);
        logic [7:0] mb[4], rb[4], ob[4];
        int k, h;
        k = int'(addr[1:0]);
        h = k & 2;
        for (int i = 0; i < 4; i++) begin
            mb[i] = mem[8*i +: 8];
            rb[i] = rt[8*i +: 8];
            ob[i] = 8'h00;
        end
        case (op)
            4'd1: begin ob[0] = mb[k]; for (int i = 1; i < 4; i++) ob[i] = {8{mb[k][7]}}; end
            4'd2: ob[0] = mb[k];
            4'd3: begin ob[0] = mb[h]; ob[1] = mb[h+1]; ob[2] = {8{mb[h+1][7]}}; ob[3] = ob[2]; end
            4'd4: begin ob[0] = mb[h]; ob[1] = mb[h+1]; end
            4'd5: for (int i = 0; i < 4; i++) ob[i] = mb[i];
            4'd9:  for (int i = 0; i < 4; i++) ob[i] = (i >= 3 - k) ? mb[i - (3 - k)] : rb[i];
            4'd10: for (int i = 0; i < 4; i++) ob[i] = (i <= 3 - k) ? mb[i + k] : rb[i];
            default: ;
        endcase
        return {ob[3], ob[2], ob[1], ob[0]};
    endfunction

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_o", 32'(stall_o), 32'(exp_stall));
            chk("data_req", 32'(data_req), 32'(exp_req));
            chk("done_o", 32'(done_o), 32'(exp_done));
            chk("adel_o", 32'(adel_o), 32'(valid_i && m_is_load(op_i) && m_misaligned(op_i, addr_i)));
            chk("ades_o", 32'(ades_o), 32'(valid_i && m_is_store(op_i) && m_misaligned(op_i, addr_i)));
            chk("badvaddr_o", badvaddr_o, addr_i);
            if (exp_fld) begin
                chk("data_addr", data_addr, exp_addr);
                chk("data_size", 32'(data_size), 32'(exp_size));
                chk("data_wr", 32'(data_wr), 32'(exp_wr));
                chk("data_wstrb", 32'(data_wstrb), 32'(exp_wstrb));
                if (exp_st) chk("data_wdata", data_wdata, exp_wdata);
            end
            if (exp_done && exp_ld) chk("rdata_o", rdata_o, exp_rdata);
            if (exp_zero) begin
                chk("rst_wr", 32'(data_wr), 32'h0);
                chk("rst_wstrb", 32'(data_wstrb), 32'h0);
                chk("rst_size", 32'(data_size), 32'h0);
                chk("rst_addr", data_addr, 32'h0);
                chk("rst_wdata", data_wdata, 32'h0);
                chk("rst_rdata", rdata_o, 32'h0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        valid_i = 1'b0; flush_i = 1'b0; exp_stall = 1'b0; exp_req = 1'b0;
        exp_done = 1'b0; exp_fld = 1'b0;
    endtask

    // fm: 0 none, 1 flush in REQ before addr_ok, 2 flush in WAIT, 3 flush with addr_ok
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] mem, input int ad, input int dd, input int fm);
        bit ld, st, flushed;
        logic [3:0]  s;
        logic [31:0] d;
        ld = m_is_load(op);
        st = m_is_store(op);
        flushed = (fm != 0);
        valid_i = 1'b1; op_i = op; addr_i = addr; rt_i = rt; flush_i = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        exp_req = 1'b0; exp_done = 1'b0; exp_fld = 1'b0;
        if (!(ld || st) || m_misaligned(op, addr)) begin
            exp_stall = 1'b0;
            cyc();
            go_idle();
            return;
        end
        exp_ld = ld; exp_st = st; exp_wr = st;
        exp_addr = m_phys(op, addr); exp_size = m_size(op);
        m_store(op, addr, rt, s, d);
        exp_wstrb = st ? s : 4'b0000; exp_wdata = d;
        exp_rdata = m_load(op, addr, rt, mem);
        exp_stall = 1'b1;
        cyc();
        exp_req = 1'b1; exp_fld = 1'b1;
        for (int c = 0; c < ad; c++) begin
            if (fm == 1 && c == 0) flush_i = 1'b1;
            cyc();
            if (fm == 1) begin go_idle(); return; end
        end
        data_addr_ok = 1'b1;
        if (dd == 0) begin data_data_ok = 1'b1; data_rdata = mem; end
        if (fm == 3) flush_i = 1'b1;
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; flush_i = 1'b0; data_rdata = $urandom;
        exp_req = 1'b0; exp_fld = 1'b0;
        if (fm == 3) valid_i = 1'b0;
        for (int c = 1; c < dd; c++) begin
            if (fm == 2 && c == 1) flush_i = 1'b1;
            cyc();
            flush_i = 1'b0;
            if (flushed) valid_i = 1'b0;
        end
        if (dd > 0) begin
            data_data_ok = 1'b1; data_rdata = mem;
            cyc();
            data_data_ok = 1'b0; data_rdata = $urandom;
        end
        if (!flushed) begin
            exp_done = 1'b1; exp_stall = 1'b0;
            cyc();
        end
        go_idle();
    endtask

    // Reset while waiting for data. A stray data_data_ok afterwards must be ignored.
    task automatic reset_mid();
        valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h0000_0040; rt_i = 32'h0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_fld = 1'b0;
        cyc();
        exp_req = 1'b1; data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0; exp_req = 1'b0; rst = 1'b1; valid_i = 1'b0; exp_stall = 1'b0;
        cyc();
        rst = 1'b0; exp_zero = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        cyc();
        exp_zero = 1'b0; data_data_ok = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] raddr, s_d;
        logic [3:0]  s_s;
        int          rad, rdd, rfm, r;

        rst = 1'b1; valid_i = 1'b0; op_i = 4'h0; addr_i = 32'h0; rt_i = 32'h0; flush_i = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        chk_en = 1'b0; exp_zero = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
        exp_fld = 1'b0; exp_ld = 1'b0; exp_st = 1'b0; exp_wr = 1'b0; exp_size = 2'd0;
        exp_wstrb = 4'h0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;
        cyc();
        chk_en = 1'b1; exp_zero = 1'b1;
        cyc();
        cyc();
        rst = 1'b0; exp_zero = 1'b0;
        cyc();

        // Hand-computed pins on the model
        chk("pin_lb_rdata", m_load(4'd1, 32'h8000_0003, 32'h0, 32'h8F00_0000), 32'hFFFF_FF8F);
        chk("pin_lb_addr", m_phys(4'd1, 32'h8000_0003), 32'h0000_0003);
        chk("pin_lb_size", 32'(m_size(4'd1)), 32'h0);
        chk("pin_sh_addr", m_phys(4'd7, 32'hA000_0002), 32'h0000_0002);
        m_store(4'd7, 32'hA000_0002, 32'h1234_ABCD, s_s, s_d);
        chk("pin_sh_wdata", s_d, 32'hABCD_ABCD);
        chk("pin_sh_wstrb", 32'(s_s), 32'hC);
        chk("pin_lw_misalign", 32'(m_misaligned(4'd5, 32'h0000_1002)), 32'h1);
        chk("pin_lhu", m_load(4'd4, 32'h0000_0002, 32'h0, 32'h8001_7F00), 32'h0000_8001);
`ifdef MEM_UNALIGNED_LWLR_EN
        chk("pin_lwl", m_load(4'd9, 32'h0000_0101, 32'h1122_3344, 32'hAABB_CCDD), 32'hCCDD_3344);
        chk("pin_lwr", m_load(4'd10, 32'h0000_0101, 32'h1122_3344, 32'hAABB_CCDD), 32'h11AA_BBCC);
`endif

        // Directed transactions
        run_op(4'd1, 32'h8000_0003, 32'h0, 32'h8F00_0000, 0, 0, 0);
        run_op(4'd7, 32'hA000_0002, 32'h1234_ABCD, 32'h0, 0, 0, 0);
        run_op(4'd5, 32'h0000_1002, 32'h0, 32'h0, 0, 0, 0);
        run_op(4'd5, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 2, 2, 0);
        run_op(4'd5, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 0, 3, 2);
        run_op(4'd2, 32'h0000_0200, 32'h0, 32'h0000_0080, 2, 1, 1);
        run_op(4'd0, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 0);
        run_op(4'd8, 32'h9000_0010, 32'hCAFE_F00D, 32'h0, 1, 2, 3);
`ifdef MEM_UNALIGNED_LWLR_EN
        run_op(4'd9, 32'h0000_0101, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       raddr = {3'b100, 29'($urandom)};
                1:       raddr = {3'b101, 29'($urandom)};
                2:       raddr = {2'b00, 30'($urandom)};
                default: raddr = {2'b11, 30'($urandom)};
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (m_size(rop) == 2'd1) raddr[0] = 1'b0;
                if (m_size(rop) == 2'd2 && rop <= 4'd8) raddr[1:0] = 2'b00;
            end
            rad = $urandom_range(0, 3);
            rdd = $urandom_range(0, 3);
            r   = $urandom_range(0, 9);
            rfm = 0;
            if (r == 0 && rad >= 1)      rfm = 1;
            else if (r == 1 && rdd >= 2) rfm = 2;
            else if (r == 2 && rdd >= 1) rfm = 3;
            run_op(rop, raddr, $urandom, $urandom, rad, rdd, rfm);
            if ($urandom_range(0, 4) == 0) begin
                go_idle();
                cyc();
            end
        end

        reset_mid();
        go_idle();
        cyc();
        cyc();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
